// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and the receiver state type.
//   KBAUD_DEFAULT : clock cycles per bit (100 MHz / 9600 baud), same as UartTx
//   DATA_BITS     : data bits per frame (8N1)
//   rx_state_e    : receiver FSM states
//   maj3()        : 2-of-3 majority vote, used when UART_RX_MAJORITY_EN is set
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [13:0] KBAUD_DEFAULT = 14'd10416;
   localparam int unsigned DATA_BITS     = 8;
   localparam int unsigned BIT_CNT_W     = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous input plus an edge register.
// All flops reset to 1 so an idle-high line never shows a false falling edge
// when reset releases.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_line    in   asynchronous input
//   out_line   out  synchronised line (2 clk after the pin)
//   out_fFall  out  one-cycle pulse: previous sample 1, current sample 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic in_line,
   output logic out_line,
   output logic out_fFall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = in_line;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign out_line  = sync_q;
   assign out_fFall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver. Finds the start-bit falling edge, samples
// each bit at its middle, and presents the byte with a one-cycle valid strobe.
// A stop bit sampled low gives a one-cycle frame-error strobe instead.
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   in_DataBit    in   serial line (asynchronous, idles high)
//   out_DataByte  out  last good byte, held until the next good frame
//   out_fValid    out  one-cycle pulse: out_DataByte just updated
//   out_fFrameErr out  one-cycle pulse: stop bit sampled low
//   out_fBusy     out  FSM not in IDLE
// Build option: UART_RX_MAJORITY_EN -- each bit decision is a 2-of-3 vote over
// the synchronised samples at tick-1, tick, tick+1, acted on one clk later.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter logic [13:0] KBAUD = KBAUD_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_DataBit,
   output logic [7:0] out_DataByte,
   output logic       out_fValid,
   output logic       out_fFrameErr,
   output logic       out_fBusy
);

   localparam logic [13:0] HALF_KBAUD = KBAUD / 14'd2;

   rx_state_e                state_q, state_d;
   logic [13:0]              cnt_q, cnt_d;
   logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]     shift_q, shift_d;
   logic [DATA_BITS-1:0]     data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     ferr_q, ferr_d;

   logic        line_sync;
   logic        start_edge;
   logic [13:0] target;
   logic        tick;
   logic        act;
   logic        bit_val;

   uart_rx_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_line   (in_DataBit),
      .out_line  (line_sync),
      .out_fFall (start_edge)
   );

   always_comb begin
      target = (state_q == START) ? (HALF_KBAUD - 14'd1) : (KBAUD - 14'd1);
   end

   assign tick = (cnt_q == target) && (state_q != IDLE);

`ifdef UART_RX_MAJORITY_EN
   logic line_d1_q, line_d1_d;
   logic line_d2_q, line_d2_d;
   logic pend_q, pend_d;

   always_comb begin
      line_d1_d = line_sync;
      line_d2_d = line_d1_q;
      pend_d    = tick;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_d1_q <= 1'b1;
         line_d2_q <= 1'b1;
         pend_q    <= 1'b0;
      end else begin
         line_d1_q <= line_d1_d;
         line_d2_q <= line_d2_d;
         pend_q    <= pend_d;
      end
   end

   // One clk after the tick: the current sample is tick+1, the history holds
   // tick and tick-1.
   assign act     = pend_q;
   assign bit_val = maj3(line_d2_q, line_d1_q, line_sync);
`else
   assign act     = tick;
   assign bit_val = line_sync;
`endif

   // The counter clears at the tick rather than at the (possibly delayed)
   // state change, so the voted build keeps the bit grid of the single-sample
   // build; in that build every non-IDLE state entry coincides with a tick.
   always_comb begin
      if (tick || (state_q == IDLE && start_edge)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 14'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = START;
            end
         end
         START: begin
            if (act) begin
               if (bit_val) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (act) begin
               shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (act) begin
               state_d = IDLE;
               if (bit_val) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign out_DataByte  = data_q;
   assign out_fValid    = valid_q;
   assign out_fFrameErr = ferr_q;
   assign out_fBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives 8N1 frames onto in_DataBit and checks received bytes, frame errors,
// latency, glitch rejection and mid-frame reset against a frame-level model.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int K    = 16;
   localparam int HALF = K / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT_NOM = 2 + HALF + 9 * K + EXTRA;

   logic       clk;
   logic       rst_n;
   logic       line;
   logic [7:0] out_DataByte;
   logic       out_fValid;
   logic       out_fFrameErr;
   logic       out_fBusy;

   uart_rx #(.KBAUD(14'(K))) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_DataBit    (line),
      .out_DataByte  (out_DataByte),
      .out_fValid    (out_fValid),
      .out_fFrameErr (out_fFrameErr),
      .out_fBusy     (out_fBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // expected byte stream: written by the stimulus, consumed by the monitor
   logic [7:0] exp_arr [0:63];
   int exp_wr    = 0;
   int exp_rd    = 0;
   int exp_ferr  = 0;
   int got_ferr  = 0;
   int got_valid = 0;
   int got_unexp = 0;
   int busy_cnt  = 0;
   int fall_cyc  = 0;
   logic [7:0] last_good = 8'h00;
   logic       prev_strobe = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_arr[exp_wr] = b;
      exp_wr++;
   endtask

   // glitch_bit >= 0 inverts that data bit for one clk at its sampling point
   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, input int glitch_bit);
      fall_cyc = cyc;
      line = 1'b0;
      wait_cycles(K);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         if (i == glitch_bit) begin
            wait_cycles(HALF);
            line = ~b[i];
            wait_cycles(1);
            line = b[i];
            wait_cycles(K - HALF - 1);
         end else begin
            wait_cycles(K);
         end
      end
      line = stop;
      wait_cycles(K);
      line = 1'b1;
      wait_cycles(gap * K);
   endtask

   task automatic monitor();
      int lat;
      int dev;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_fBusy) busy_cnt++;
            if (out_fValid || out_fFrameErr) begin
               check_eq("strobe_excl", {30'd0, out_fValid & out_fFrameErr, prev_strobe}, 32'd0);
            end
            if (out_fValid) begin
               got_valid++;
               lat = cyc - fall_cyc;
               dev = (lat > LAT_NOM) ? lat - LAT_NOM : LAT_NOM - lat;
               check_eq("latency", (dev <= 1) ? LAT_NOM : lat, LAT_NOM);
               if (exp_rd < exp_wr) begin
                  check_eq("data_byte", {24'd0, out_DataByte}, {24'd0, exp_arr[exp_rd]});
                  last_good = exp_arr[exp_rd];
                  exp_rd++;
               end else begin
                  got_unexp++;
               end
            end
            if (out_fFrameErr) begin
               got_ferr++;
               check_eq("hold_on_ferr", {24'd0, out_DataByte}, {24'd0, last_good});
            end
            prev_strobe = out_fValid | out_fFrameErr;
         end else begin
            prev_strobe = 1'b0;
            last_good   = 8'h00;
         end
      end
   endtask

   initial begin
      int base_busy;
      int base_strb;
      int d;
      logic [7:0] b;
      logic       err;
      int         gap;
      logic [7:0] abort_byte;

      line  = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_byte",  {24'd0, out_DataByte}, 32'd0);
      check_eq("rst_valid", {31'd0, out_fValid},    32'd0);
      check_eq("rst_ferr",  {31'd0, out_fFrameErr}, 32'd0);
      check_eq("rst_busy",  {31'd0, out_fBusy},     32'd0);
      wait_cycles(3);
      rst_n = 1'b1;

      fork
         monitor();
      join_none

      wait_cycles(2 * K);
      check_eq("idle_busy", {31'd0, out_fBusy}, 32'd0);

      // back to back 50 then 120
      expect_byte(8'd50);
      send_frame(8'd50, 1'b1, 0, -1);
      expect_byte(8'd120);
      send_frame(8'd120, 1'b1, 1, -1);

      // bad stop bit
      exp_ferr++;
      send_frame(8'hA5, 1'b0, 2, -1);

      // short low glitch on idle line
      base_busy = busy_cnt;
      base_strb = got_valid + got_ferr;
      line = 1'b0;
      wait_cycles(3);
      line = 1'b1;
      wait_cycles(3 * K);
      d = busy_cnt - base_busy;
      check_eq("glitch_busy", (d >= HALF - 1 && d <= HALF + 3) ? HALF : d, HALF);
      check_eq("glitch_strobes", got_valid + got_ferr, base_strb);
      check_eq("glitch_idle", {31'd0, out_fBusy}, 32'd0);

      // reset during data bit 4; bits 4..7 high so the tail shows no edge
      abort_byte = 8'hF5;
      line = 1'b0;
      wait_cycles(K);
      for (int i = 0; i < 4; i++) begin
         line = abort_byte[i];
         wait_cycles(K);
      end
      line = abort_byte[4];
      wait_cycles(HALF);
      check_eq("pre_rst_busy", {31'd0, out_fBusy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_byte",  {24'd0, out_DataByte}, 32'd0);
      check_eq("arst_valid", {31'd0, out_fValid},    32'd0);
      check_eq("arst_ferr",  {31'd0, out_fFrameErr}, 32'd0);
      check_eq("arst_busy",  {31'd0, out_fBusy},     32'd0);
      wait_cycles(3);
      rst_n = 1'b1;
      base_strb = got_valid + got_ferr;
      wait_cycles((K - HALF - 3) + 4 * K + 2 * K);
      check_eq("abort_strobes", got_valid + got_ferr, base_strb);
      check_eq("abort_idle", {31'd0, out_fBusy}, 32'd0);
      expect_byte(8'h3C);
      send_frame(8'h3C, 1'b1, 1, -1);

      // random frames, some with bad stop bits
      for (int n = 0; n < 16; n++) begin
         b   = 8'($urandom);
         err = ($urandom_range(0, 4) == 0);
         if (err) begin
            exp_ferr++;
            gap = $urandom_range(1, 2);
         end else begin
            expect_byte(b);
            gap = $urandom_range(0, 2);
         end
         send_frame(b, ~err, gap, -1);
      end

`ifdef UART_RX_MAJORITY_EN
      expect_byte(8'h96);
      send_frame(8'h96, 1'b1, 1, 3);
`endif

      wait_cycles(2 * K);
      check_eq("all_bytes_seen", exp_rd, exp_wr);
      check_eq("valid_count", got_valid, exp_wr);
      check_eq("unexp_valid", got_unexp, 32'd0);
      check_eq("ferr_count", got_ferr, exp_ferr);
      check_eq("end_idle", {31'd0, out_fBusy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
